// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that wait on the memory handshake and are covered by the timeout
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags a timeout on the last allowed one.
module mips_mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic timeout
);

    logic [7:0] wait_cnt;

    // Wait counter: zeroed whenever the FSM changes state, so it starts at 0 on entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (clear) begin
            wait_cnt <= 8'd0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Timeout only fires on a stalled cycle; a ready on the same cycle is not a stall
    always_comb begin
        timeout = stall && (wait_cnt == 8'(MAX_WAIT - 1));
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath with wait states, timeout and traps.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             retired,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    state_t           state_reg, state_next;
    logic [1:0]       cause_reg, cause_next;
    logic [CNT_W-1:0] count_reg;
    logic             stall;
    logic             timeout;
    logic             timer_clear;

    assign stall       = is_mem_state(state_reg) && !mem_ready;
    assign timer_clear = (state_next != state_reg);

    mips_mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .stall   (stall),
        .timeout (timeout)
    );

    // State, sticky trap cause and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cause_reg <= CAUSE_NONE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (retired) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    // Next-state logic and Moore outputs (FETCH/MEM_WRITE also look at mem_ready)
    always_comb begin
        state_next    = state_reg;
        cause_next    = cause_reg;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        trap          = 1'b0;
        retired       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                // IR still holds the opcode, only lw/sw can reach here
                state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retired    = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REGB;
                alu_op     = ALUOP_FUNCT;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retired       = 1'b1;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                // Parked with every datapath enable low until reset
                trap = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign trap_cause  = cause_reg;
    assign instr_count = count_reg;
    assign state_dbg   = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed test of the multicycle MIPS control FSM with hand-computed expectations.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        retired;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    logic [19:0] all_out;
    logic [15:0] dp_out;

    assign dp_out  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    assign all_out = {dp_out, trap, trap_cause, retired};

    mips_multicycle_ctrl #(
        .MAX_WAIT (4),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .retired       (retired),
        .instr_count   (instr_count),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        tick();
        tick();
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_outs", 32'(all_out), 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // R-type: 1,2,7,8,1
        reset = 1'b0;
        #1;
        chk("idle_state", 32'(state_dbg), 32'd0);
        tick();
        chk("r_fetch_state", 32'(state_dbg), 32'd1);
        chk("r_fetch_mem_read", 32'(mem_read), 32'd1);
        chk("r_fetch_srcb", 32'(alu_src_b), 32'd1);
        chk("r_fetch_ir_write", 32'(ir_write), 32'd1);
        chk("r_fetch_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("r_decode_state", 32'(state_dbg), 32'd2);
        chk("r_decode_srcb", 32'(alu_src_b), 32'd3);
        tick();
        chk("r_exec_state", 32'(state_dbg), 32'd7);
        chk("r_exec_aluop", 32'(alu_op), 32'd2);
        chk("r_exec_srca", 32'(alu_src_a), 32'd1);
        tick();
        chk("r_wb_state", 32'(state_dbg), 32'd8);
        chk("r_wb_reg_write", 32'(reg_write), 32'd1);
        chk("r_wb_reg_dst", 32'(reg_dst), 32'd1);
        chk("r_wb_retired", 32'(retired), 32'd1);
        chk("r_wb_count", instr_count, 32'd0);
        tick();
        chk("r_done_state", 32'(state_dbg), 32'd1);
        chk("r_done_retired", 32'(retired), 32'd0);
        chk("r_done_count", instr_count, 32'd1);

        // lw with two wait cycles in MEM_READ
        opcode = 6'b100011;
        tick();
        chk("lw_decode", 32'(state_dbg), 32'd2);
        tick();
        chk("lw_addr_state", 32'(state_dbg), 32'd3);
        chk("lw_addr_srcb", 32'(alu_src_b), 32'd2);
        mem_ready = 1'b0;
        tick();
        chk("lw_rd1_state", 32'(state_dbg), 32'd4);
        chk("lw_rd1_iord", 32'(iord), 32'd1);
        chk("lw_rd1_mem_read", 32'(mem_read), 32'd1);
        tick();
        chk("lw_rd2_state", 32'(state_dbg), 32'd4);
        tick();
        chk("lw_rd3_state", 32'(state_dbg), 32'd4);
        mem_ready = 1'b1;
        #1;
        chk("lw_rd3_retired", 32'(retired), 32'd0);
        tick();
        chk("lw_wb_state", 32'(state_dbg), 32'd5);
        chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("lw_wb_reg_write", 32'(reg_write), 32'd1);
        chk("lw_wb_retired", 32'(retired), 32'd1);
        tick();
        chk("lw_done_state", 32'(state_dbg), 32'd1);
        chk("lw_done_count", instr_count, 32'd2);

        // beq
        opcode = 6'b000100;
        tick();
        tick();
        chk("beq_state", 32'(state_dbg), 32'd9);
        chk("beq_aluop", 32'(alu_op), 32'd1);
        chk("beq_pwc", 32'(pc_write_cond), 32'd1);
        chk("beq_pcsrc", 32'(pc_source), 32'd1);
        tick();
        chk("beq_done_state", 32'(state_dbg), 32'd1);
        chk("beq_done_count", instr_count, 32'd3);

        // j
        opcode = 6'b000010;
        tick();
        tick();
        chk("j_state", 32'(state_dbg), 32'd10);
        chk("j_pc_write", 32'(pc_write), 32'd1);
        chk("j_pcsrc", 32'(pc_source), 32'd2);
        tick();
        chk("j_done_count", instr_count, 32'd4);

        // addi
        opcode = 6'b001000;
        tick();
        tick();
        chk("addi_exec_state", 32'(state_dbg), 32'd11);
        chk("addi_exec_srcb", 32'(alu_src_b), 32'd2);
        tick();
        chk("addi_wb_state", 32'(state_dbg), 32'd12);
        chk("addi_wb_reg_write", 32'(reg_write), 32'd1);
        chk("addi_wb_reg_dst", 32'(reg_dst), 32'd0);
        tick();
        chk("addi_done_count", instr_count, 32'd5);

        // sw with one wait cycle
        opcode = 6'b101011;
        tick();
        tick();
        chk("sw_addr_state", 32'(state_dbg), 32'd3);
        mem_ready = 1'b0;
        tick();
        chk("sw_wr_state", 32'(state_dbg), 32'd6);
        chk("sw_wr_mem_write", 32'(mem_write), 32'd1);
        chk("sw_wr_iord", 32'(iord), 32'd1);
        chk("sw_wr_retired_wait", 32'(retired), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("sw_wr_retired", 32'(retired), 32'd1);
        tick();
        chk("sw_done_state", 32'(state_dbg), 32'd1);
        chk("sw_done_count", instr_count, 32'd6);

        // Reset asserted during MEM_WRITE
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("abort_pre_state", 32'(state_dbg), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outs", 32'(all_out), 32'd0);
        chk("abort_state", 32'(state_dbg), 32'd0);
        chk("abort_count", instr_count, 32'd0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("abort_idle", 32'(state_dbg), 32'd0);
        tick();
        chk("abort_fetch", 32'(state_dbg), 32'd1);
        chk("abort_fetch_count", instr_count, 32'd0);

        // Illegal opcode
        opcode = 6'b111111;
        tick();
        chk("ill_decode", 32'(state_dbg), 32'd2);
        tick();
        chk("ill_state", 32'(state_dbg), 32'd13);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_enables", 32'(dp_out), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ill_hold_state", 32'(state_dbg), 32'd13);
            chk("ill_hold_trap", 32'(trap), 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("ill_clear_trap", 32'(trap), 32'd0);
        chk("ill_clear_cause", 32'(trap_cause), 32'd0);
        tick();
        reset = 1'b0;

        // FETCH timeout after 4 stalled cycles (MAX_WAIT=4)
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        tick();
        chk("to_fetch1_state", 32'(state_dbg), 32'd1);
        chk("to_fetch1_ir_write", 32'(ir_write), 32'd0);
        chk("to_fetch1_mem_read", 32'(mem_read), 32'd1);
        tick();
        tick();
        tick();
        chk("to_fetch4_state", 32'(state_dbg), 32'd1);
        tick();
        chk("to_trap_state", 32'(state_dbg), 32'd13);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Ready on the 4th stalled cycle wins over the timeout
        tick();
        chk("rdy_fetch1_state", 32'(state_dbg), 32'd1);
        tick();
        tick();
        tick();
        chk("rdy_fetch4_state", 32'(state_dbg), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("rdy_fetch4_ir_write", 32'(ir_write), 32'd1);
        tick();
        chk("rdy_decode_state", 32'(state_dbg), 32'd2);
        chk("rdy_trap", 32'(trap), 32'd0);
        chk("rdy_cause", 32'(trap_cause), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
